// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit. It shadows in-flight destination tags
// and, for each source operand, picks the youngest producer stage or the register file.
module fwd_hazard_unit #(
    parameter int NUM_SRC          = 2,
    parameter int FWD_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int REG_ADDR_W       = 5,
    localparam int SEL_W           = $clog2(FWD_STAGES + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          issue_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_rs_i,
    input  logic [NUM_SRC-1:0]            issue_rs_used_i,
    input  logic [REG_ADDR_W-1:0]         issue_rd_i,
    input  logic                          issue_rd_we_i,
    input  logic                          issue_is_load_i,
    input  logic                          hold_i,
    input  logic                          flush_i,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
    output logic                          stall_o,
    output logic                          issue_fire_o,
    output logic [15:0]                   stall_count_o
);

    logic [FWD_STAGES:1]                 st_vld;
    logic [FWD_STAGES:1]                 st_ld;
    logic [FWD_STAGES:1][REG_ADDR_W-1:0] st_rd;
    logic [NUM_SRC-1:0]                  src_haz;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        logic [REG_ADDR_W-1:0] rs;
        logic [SEL_W-1:0]      sel;
        logic                  haz;

        assign rs = issue_rs_i[n*REG_ADDR_W +: REG_ADDR_W];

        // Scan oldest to youngest so the youngest match overwrites older ones.
        always_comb begin
            sel = '0;
            haz = 1'b0;
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (st_vld[k] && st_rd[k] == rs && issue_rs_used_i[n] && rs != '0) begin
                    sel = SEL_W'(k);
                    haz = st_ld[k] && (k < LOAD_READY_STAGE);
                end
            end
        end

        assign fwd_sel_o[n*SEL_W +: SEL_W] = sel;
        assign src_haz[n]                  = haz;
    end

    assign stall_o      = issue_valid_i & (|src_haz);
    assign issue_fire_o = issue_valid_i & ~stall_o & ~hold_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_vld        <= '0;
            st_ld         <= '0;
            st_rd         <= '0;
            stall_count_o <= '0;
        end else begin
            if (hold_i) begin
                // Frozen pipeline still honours a flush of the youngest entry.
                if (flush_i) st_vld[1] <= 1'b0;
            end else begin
                for (int k = FWD_STAGES; k >= 2; k--) begin
                    st_vld[k] <= st_vld[k-1];
                    st_ld[k]  <= st_ld[k-1];
                    st_rd[k]  <= st_rd[k-1];
                end
                st_vld[1] <= issue_fire_o & issue_rd_we_i & (issue_rd_i != '0);
                st_ld[1]  <= issue_is_load_i;
                st_rd[1]  <= issue_rd_i;
            end
            if (stall_o && stall_count_o != 16'hFFFF)
                stall_count_o <= stall_count_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [9:0]  rs = '0;
    logic [1:0]  used = '0;
    logic [4:0]  rd = '0;
    logic        we = 1'b0;
    logic        ld = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;

    logic [3:0]  sel0, sel1;
    logic        stall0, stall1, fire0, fire1;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    fwd_hazard_unit dut0 (
        .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(valid), .issue_rs_i(rs),
        .issue_rs_used_i(used), .issue_rd_i(rd), .issue_rd_we_i(we),
        .issue_is_load_i(ld), .hold_i(hold), .flush_i(flush),
        .fwd_sel_o(sel0), .stall_o(stall0), .issue_fire_o(fire0), .stall_count_o(cnt0)
    );

    fwd_hazard_unit #(.FWD_STAGES(3), .LOAD_READY_STAGE(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(valid), .issue_rs_i(rs),
        .issue_rs_used_i(used), .issue_rd_i(rd), .issue_rd_we_i(we),
        .issue_is_load_i(ld), .hold_i(hold), .flush_i(flush),
        .fwd_sel_o(sel1), .stall_o(stall1), .issue_fire_o(fire1), .stall_count_o(cnt1)
    );

    typedef struct {
        string       name;
        int          dut;
        logic [3:0]  sel;
        logic        stall;
        logic        fire;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    exp_t        mon_e;
    logic [21:0] mon_act, mon_exp;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = (mon_e.dut == 1) ? {sel1, stall1, fire1, cnt1} : {sel0, stall0, fire0, cnt0};
            mon_exp = {mon_e.sel, mon_e.stall, mon_e.fire, mon_e.cnt};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL %s: got sel=%h stall=%b fire=%b cnt=%h, want sel=%h stall=%b fire=%b cnt=%h",
                         mon_e.name, mon_act[21:18], mon_act[17], mon_act[16], mon_act[15:0],
                         mon_e.sel, mon_e.stall, mon_e.fire, mon_e.cnt);
            end
        end
    end

    task automatic drv(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] u, input logic [4:0] d, input logic w,
                       input logic l, input logic h, input logic f);
        @(posedge clk);
        #1;
        valid = v; rs = {r1, r0}; used = u; rd = d; we = w; ld = l; hold = h; flush = f;
    endtask

    task automatic vec(input string nm, input int dsel, input logic v,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u,
                       input logic [4:0] d, input logic w, input logic l,
                       input logic h, input logic f,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic st, input logic fi, input logic [15:0] c);
        exp_t e;
        drv(v, r0, r1, u, d, w, l, h, f);
        e.name = nm; e.dut = dsel; e.sel = {s1, s0}; e.stall = st; e.fire = fi; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic set_rst(input logic r);
        @(posedge clk);
        #1;
        valid = 0; rs = '0; used = '0; rd = '0; we = 0; ld = 0; hold = 0; flush = 0;
        rst_n = r;
    endtask

    initial begin
        //   name           dut v  rs0 rs1 used  rd  we ld h  f   s0 s1 st fi cnt
        vec("rst_state",     0, 1, 5,  0,  2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        vec("rst_hold",      0, 1, 5,  0,  2'b01, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
        set_rst(1);
        vec("alu_prod",      0, 1, 0,  0,  2'b00, 5, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        vec("alu_b2b",       0, 1, 5,  5,  2'b11, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0);
        vec("alu_stage2",    0, 1, 5,  5,  2'b11, 0, 0, 0, 0, 0,  2, 2, 0, 1, 0);
        vec("alu_retired",   0, 1, 5,  5,  2'b11, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        vec("x7_first",      0, 1, 0,  0,  2'b00, 7, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        vec("x7_second",     0, 1, 7,  0,  2'b01, 7, 1, 0, 0, 0,  1, 0, 0, 1, 0);
        vec("youngest_wins", 0, 1, 7,  0,  2'b01, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
        vec("load_x3",       0, 1, 0,  0,  2'b00, 3, 1, 1, 0, 0,  0, 0, 0, 1, 0);
        vec("load_use",      0, 1, 0,  3,  2'b10, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
        vec("load_fwd2",     0, 1, 0,  3,  2'b10, 0, 0, 0, 0, 0,  0, 2, 0, 1, 1);
        vec("x0_prod",       0, 1, 0,  0,  2'b00, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1);
        vec("x0_read",       0, 1, 0,  0,  2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        vec("load_x4",       0, 1, 0,  0,  2'b00, 4, 1, 1, 0, 0,  0, 0, 0, 1, 1);
        vec("unused_src",    0, 1, 4,  0,  2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        vec("flush_issue",   0, 1, 0,  0,  2'b00, 6, 1, 0, 0, 1,  0, 0, 0, 0, 1);
        vec("flushed_rd",    0, 1, 6,  0,  2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        vec("load_x9",       0, 1, 0,  0,  2'b00, 9, 1, 1, 0, 0,  0, 0, 0, 1, 1);
        vec("hold_stall1",   0, 1, 9,  0,  2'b01, 0, 0, 0, 1, 0,  1, 0, 1, 0, 1);
        vec("hold_stall2",   0, 1, 9,  0,  2'b01, 0, 0, 0, 1, 0,  1, 0, 1, 0, 2);
        vec("hold_stall3",   0, 1, 9,  0,  2'b01, 0, 0, 0, 1, 0,  1, 0, 1, 0, 3);
        vec("stall_unhold",  0, 1, 9,  0,  2'b01, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4);
        vec("hold_release",  0, 1, 9,  0,  2'b01, 0, 0, 0, 0, 0,  2, 0, 0, 1, 5);
        vec("load_x10",      0, 1, 0,  0,  2'b00, 10, 1, 1, 0, 0, 0, 0, 0, 1, 5);
        vec("hold_flush",    0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 1,  0, 0, 0, 0, 5);
        vec("after_hflush",  0, 1, 10, 0,  2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 1, 5);
        vec("load_x5",       0, 1, 0,  0,  2'b00, 5, 1, 1, 0, 0,  0, 0, 0, 1, 5);
        set_rst(0);
        vec("in_reset",      0, 1, 5,  0,  2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        set_rst(1);
        vec("post_reset",    0, 1, 5,  0,  2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);

        // Saturation: a load held in stage 1 stalls every cycle.
        vec("sat_load",      0, 1, 0,  0,  2'b00, 9, 1, 1, 0, 0,  0, 0, 0, 1, 0);
        for (int i = 0; i <= 65536; i++) begin
            if (i >= 65533)
                vec("sat_count", 0, 1, 9, 0, 2'b01, 0, 0, 0, 1, 0, 1, 0, 1, 0,
                    (i > 65535) ? 16'hFFFF : 16'(i));
            else
                drv(1, 9, 0, 2'b01, 0, 0, 0, 1, 0);
        end

        // Deeper pipeline: loads only forwardable from stage 3.
        set_rst(0);
        set_rst(1);
        vec("d3_load",       1, 1, 0,  0,  2'b00, 3, 1, 1, 0, 0,  0, 0, 0, 1, 0);
        vec("d3_stall1",     1, 1, 0,  3,  2'b10, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
        vec("d3_stall2",     1, 1, 0,  3,  2'b10, 0, 0, 0, 0, 0,  0, 2, 1, 0, 1);
        vec("d3_fire",       1, 1, 0,  3,  2'b10, 0, 0, 0, 0, 0,  0, 3, 0, 1, 2);

        set_rst(1);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the in-order integer pipeline. It tracks the destination tags of in-flight instructions in its own shadow pipeline of configurable depth. For every source operand at issue, it selects the youngest matching producer stage, or the register file when no stage matches. It asserts a stall when the matching producer is a load whose data is not yet available, and counts stall cycles for performance monitoring.

## Interface
- `NUM_SRC`, 2: source operands per instruction.
- `FWD_STAGES`, 2: producer stages tracked after issue; stage 1 is the youngest (EX).
- `LOAD_READY_STAGE`, 2: first stage whose load result can be forwarded; range 1..`FWD_STAGES`.
- `REG_ADDR_W`, 5: register address width.
- `SEL_W`, derived: `$clog2(FWD_STAGES+1)`.
- Ports:
  - `clk_i` in 1: clock.
  - `rst_ni` in 1: reset, asynchronous, active-low.
  - `issue_valid_i` in 1: an instruction is presented at issue.
  - `issue_rs_i` in `NUM_SRC*REG_ADDR_W`: source addresses; source n occupies slice n.
  - `issue_rs_used_i` in `NUM_SRC`: source n is actually read.
  - `issue_rd_i` in `REG_ADDR_W`: destination address.
  - `issue_rd_we_i` in 1: instruction writes `issue_rd_i`.
  - `issue_is_load_i` in 1: instruction is a load.
  - `hold_i` in 1: downstream freeze; the tag pipeline does not advance.
  - `flush_i` in 1: squashes the issuing instruction and the stage-1 entry.
  - `fwd_sel_o` out `NUM_SRC*SEL_W`: per source, 0 = register file, k = forward from stage k.
  - `stall_o` out 1: load-use hazard.
  - `issue_fire_o` out 1: the instruction is accepted this cycle.
  - `stall_count_o` out 16: saturating count of cycles with `stall_o` high.

## Operation
- Each stage k (1..`FWD_STAGES`) holds {valid, rd, is_load}.
- An entry is created only when it writes a register:
  - valid = `issue_rd_we_i` and `issue_rd_i` != 0.
  - Register x0 never matches any source.
- Source n matches stage k when all of the following hold:
  - stage k is valid;
  - stage k rd equals rs[n];
  - `issue_rs_used_i`[n] is 1;
  - rs[n] != 0.
- `fwd_sel_o`[n] is the smallest matching k (youngest producer wins), or 0 if nothing matches.
- Load-use hazard: `stall_o` = `issue_valid_i` and, for some n, the selected stage k is a load and k < `LOAD_READY_STAGE`.
- `issue_fire_o` = `issue_valid_i` & ~`stall_o` & ~`hold_i` & ~`flush_i`.
- Tag pipeline update at the clock edge, in priority order:
  1. `hold_i` = 1: all stages keep their contents. `flush_i` is still applied and clears stage 1 valid.
  2. Otherwise, stage k+1 takes stage k. Stage 1 takes the new entry if `issue_fire_o` is 1, otherwise a bubble (valid = 0). The oldest stage's entry retires.
- When `flush_i` and `issue_valid_i` are asserted together, the flush wins: no issue and a bubble enters stage 1. A stall in the same cycle does not change this.
- `stall_count_o` increments in every cycle where `stall_o` = 1, and holds at 0xFFFF once it reaches it.
- Reset mid-operation clears every valid bit and the counter immediately. In-flight tags are lost, and the surrounding pipeline is reset as well.

## Timing
- `fwd_sel_o`, `stall_o` and `issue_fire_o` are combinational from the current stage contents and the issue inputs, within the same cycle.
- State changes only at the rising edge of `clk_i`.
- An issued instruction occupies stage 1 in the next cycle and stage k after k cycles, provided no `hold_i` intervenes.
- Reset values:
  - all stage valid bits = 0;
  - `stall_count_o` = 0;
  - consequently `fwd_sel_o` = 0 and `stall_o` = 0, and `issue_fire_o` equals `issue_valid_i` gated by `hold_i` and `flush_i`.
- A load-use stall with defaults lasts exactly 1 cycle:
  - the load moves from stage 1 to stage 2 and a bubble enters stage 1;
  - the dependent instruction then fires with sel = 2.
- While `hold_i` is high, a stall persists without aging. `stall_count_o` still counts those cycles.

## Test plan
- **Reset:** assert `rst_ni` = 0 mid-stream with valid tags present, then issue rs1 = 5 → `fwd_sel_o` = 0, `stall_o` = 0, `stall_count_o` = 0.
- **ALU back-to-back:**
  - issue add x5 (we = 1), then issue rs1 = x5, rs2 = x5 → both sels = 1, no stall;
  - one cycle later, with a bubble in between → sels = 2;
  - after 3 cycles → sels = 0.
- **Youngest wins:** issue x7 producer, then another x7 producer, then rs1 = x7 → sel = 1, not 2.
- **Load-use:**
  - issue a load to x3, then rs2 = x3 → `stall_o` = 1 for 1 cycle and `stall_count_o` = 1;
  - next cycle → fire with sel = 2.
  - The same case with `LOAD_READY_STAGE` = 3 and `FWD_STAGES` = 3 → 2 stall cycles.
- **x0 and unused sources:**
  - a producer of x0 followed by rs1 = x0 → sel = 0;
  - a producer of x4 followed by rs1 = x4 with `issue_rs_used_i`[0] = 0 → sel = 0 and no stall.
- **Flush/hold interaction:**
  - flush together with a valid issue → `issue_fire_o` = 0, and the next instruction reading that rd → sel = 0;
  - hold 3 cycles with a load in stage 1 → the stall persists and `stall_count_o` increases by 3;
  - drive the counter to 0xFFFF and keep stalling → it stays at 0xFFFF.
